// File: rtl/mux_4a1.sv
// mux_4a1 -- registered 4:1 multiplexer with capture enable.
//
// On every rising edge of clk where en is high, the input chosen by sel is
// captured into outMux (sel 0..3 -> in1..in4). With en low, outMux holds.
// out_valid is en delayed by one edge, so it flags the cycle right after a
// capture. rst_n asynchronously forces outMux to RESET_VAL and out_valid low.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in1..in4   in   WIDTH-bit data inputs
//   sel        in   2-bit select code, every code is legal
//   en         in   capture enable, active high
//   outMux     out  WIDTH-bit registered mux result
//   out_valid  out  high for one cycle after each capture
//
// Handshake: out_valid is a pure qualifier with no back-pressure. When it is
// high, outMux carries the value captured at the previous edge; when it is
// low, outMux is still meaningful but is a held value, not a new capture.
module mux_4a1 #(
  parameter int unsigned            WIDTH     = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [1:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] outMux,
  output logic             out_valid
);

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] out_mux_d;
  logic [WIDTH-1:0] out_mux_q;
  logic             out_valid_d;
  logic             out_valid_q;

  // All four codes are decoded explicitly, so there is no fall-through path.
  always_comb begin
    sel_data = in1;
    unique case (sel)
      2'd0: sel_data = in1;
      2'd1: sel_data = in2;
      2'd2: sel_data = in3;
      2'd3: sel_data = in4;
    endcase
  end

  always_comb begin
    out_mux_d   = out_mux_q;
    out_valid_d = en;
    if (en) begin
      out_mux_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_mux_q   <= RESET_VAL;
      out_valid_q <= 1'b0;
    end else begin
      out_mux_q   <= out_mux_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign outMux    = out_mux_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_4a1.sv
// Testbench for mux_4a1. Inputs are driven on the falling edge, the DUT
// captures on the rising edge, and a monitor samples 2 time units after each
// rising edge. The driver pushes the hand-computed expected value for every
// enabled cycle into exp_q; the monitor pops one entry whenever out_valid is
// high and otherwise checks that outMux still holds the last value.
module tb_mux_4a1;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in1, in2, in3, in4;
  logic [1:0]   sel;
  logic         en;
  logic [W-1:0] out_mux;
  logic         out_valid;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] held;
  int           total;
  int           bad;

  mux_4a1 #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .sel       (sel),
    .en        (en),
    .outMux    (out_mux),
    .out_valid (out_valid)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d,
                       input logic [1:0] s, input logic e,
                       input logic [W-1:0] exp);
    @(negedge clk);
    in1 = a; in2 = b; in3 = c; in4 = d; sel = s; en = e;
    if (e) exp_q.push_back(exp);
  endtask

  // Short low pulse between edges; the capture already queued for the next
  // edge is discarded along with the queue.
  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(out_mux), 32'h00);
    check("midrst_valid", 32'(out_valid), 32'h0);
    exp_q.delete();
    held = '0;
    #1 rst_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        check("rst_out", 32'(out_mux), 32'h00);
        check("rst_valid", 32'(out_valid), 32'h0);
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(out_valid), 32'h0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("capture", 32'(out_mux), 32'(e));
          held = e;
        end
      end else begin
        check("hold", 32'(out_mux), 32'(held));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad   = 0;
    held  = '0;
    rst_n = 1'b1;
    en    = 1'b1;
    sel   = 2'd0;
    in1 = 8'hFF; in2 = 8'hFF; in3 = 8'hFF; in4 = 8'hFF;

    // Reset takes effect with no clock edge (first rising edge is at t=5).
    #1 rst_n = 1'b0;
    #1;
    check("por_out", 32'(out_mux), 32'h00);
    check("por_valid", 32'(out_valid), 32'h0);

    // Held in reset across edges with en=1; release away from an edge. The
    // first edge after release captures in1 (sel=0).
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(8'hFF);

    // Select sweep, back-to-back with no bubble.
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'd0, 1'b1, 8'h11);
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'd1, 1'b1, 8'h22);
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'd2, 1'b1, 8'h33);
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'd3, 1'b1, 8'h44);

    // Hold: capture A5, then 3 disabled cycles with everything changing.
    drive(8'hA5, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 8'hA5);
    drive(8'h01, 8'h02, 8'h03, 8'h04, 2'd1, 1'b0, 8'h00);
    drive(8'hF0, 8'h0F, 8'hC3, 8'h3C, 2'd2, 1'b0, 8'h00);
    drive(8'h77, 8'h88, 8'h99, 8'hAA, 2'd3, 1'b0, 8'h00);

    // Exhaustive 0/1 data sweep crossed with every select code.
    for (int combo = 0; combo < 16; combo++) begin
      for (int s = 0; s < 4; s++) begin
        logic [3:0]   bits;
        logic [W-1:0] exp;
        bits = 4'(combo);
        exp  = W'(bits[s]);
        drive(W'(bits[0]), W'(bits[1]), W'(bits[2]), W'(bits[3]), 2'(s), 1'b1, exp);
      end
    end

    // Mid-run reset during a sel sweep; the next edge captures the current
    // selection (sel=1 -> in2).
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'd0, 1'b1, 8'h11);
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'd1, 1'b1, 8'h22);
    reset_pulse();
    exp_q.push_back(8'h22);
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'd2, 1'b1, 8'h33);
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'd3, 1'b1, 8'h44);

    // Isolation: sel=2 with in3 fixed, neighbours toggling every cycle.
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] t;
      t = (i % 2 == 0) ? 8'hFF : 8'h00;
      drive(t, ~t, 8'h5A, t, 2'd2, 1'b1, 8'h5A);
    end

    // Simultaneous sel and data change at one edge.
    drive(8'h01, 8'h02, 8'h03, 8'h04, 2'd0, 1'b1, 8'h01);
    drive(8'hE1, 8'hE2, 8'hE3, 8'hC4, 2'd3, 1'b1, 8'hC4);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
